// File: rtl/exception_unit_if.sv
// Signal bundle between the exception sequencer and the datapath/control unit.
// The master side is the CPU core; the slave side is exception_unit.
interface exception_unit_if #(
   parameter int DATA_W   = 32,
   parameter int N_CAUSES = 4
);
   logic [N_CAUSES-1:0] exc_req;
   logic [N_CAUSES-1:0] exc_mask;
   logic                eret;
   logic [DATA_W-1:0]   pc_in;
   logic [DATA_W-1:0]   mem_data;
   logic                exc_active;
   logic                in_handler;
   logic [DATA_W-1:0]   epc;
   logic [DATA_W-1:0]   cause;
   logic [N_CAUSES-1:0] pending;
   logic                mem_rd;
   logic [DATA_W-1:0]   mem_addr;
   logic                pc_load;
   logic [DATA_W-1:0]   pc_target;

   modport master (
      output exc_req, exc_mask, eret, pc_in, mem_data,
      input  exc_active, in_handler, epc, cause, pending,
             mem_rd, mem_addr, pc_load, pc_target
   );

   modport slave (
      input  exc_req, exc_mask, eret, pc_in, mem_data,
      output exc_active, in_handler, epc, cause, pending,
             mem_rd, mem_addr, pc_load, pc_target
   );
endinterface

// File: rtl/exception_unit.sv
// Exception/interrupt sequencer: latches causes, picks the lowest eligible index,
// captures EPC/Cause, fetches the handler byte from the vector table and loads PC.
module exception_unit #(
   parameter int DATA_W   = 32,
   parameter int N_CAUSES = 4,
   parameter int VEC_BASE = 252,
   parameter int MEM_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   exception_unit_if.slave      bus
);
   localparam int IDX_W = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1;
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, VREQ, VWAIT, VLOAD} state_t;

   state_t              state, state_nxt;
   logic [N_CAUSES-1:0] pending, pending_nxt, eligible, take_mask;
   logic [IDX_W-1:0]    winner, cause_idx;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                in_handler, take, eret_ok;
   logic [DATA_W-1:0]   epc, vec_addr;
   logic [1:0]          lane;
   logic [7:0]          vec_byte;

   assign eligible = pending & ~bus.exc_mask;

   // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
   always_comb begin : arbiter
      winner = '0;
      for (int i = N_CAUSES - 1; i >= 0; i--) begin
         if (eligible[i]) winner = IDX_W'(i);
      end
   end

   // ERET needs in_handler=1 and a take needs in_handler=0, so ERET always wins a tie.
   assign eret_ok     = (state == IDLE) && in_handler && bus.eret;
   assign take        = (state == IDLE) && !in_handler && (eligible != '0);
   assign take_mask   = take ? (N_CAUSES'(1) << winner) : '0;
   assign pending_nxt = (pending | bus.exc_req) & ~take_mask;

   always_comb begin : next_state
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE:  if (take) state_nxt = VREQ;
         VREQ: begin
            cnt_nxt   = CNT_W'(MEM_LAT - 1);
            state_nxt = VWAIT;
         end
         VWAIT: begin
            if (cnt == '0) state_nxt = VLOAD;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         VLOAD:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         pending    <= '0;
         in_handler <= 1'b0;
         epc        <= '0;
         cause_idx  <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pending <= pending_nxt;
         if (take) begin
            epc        <= bus.pc_in;
            cause_idx  <= winner;
            in_handler <= 1'b1;
         end else if (eret_ok) begin
            in_handler <= 1'b0;
         end
      end
   end

   // Vector byte for cause idx lives at VEC_BASE+idx; fetch its word, pick the lane big-endian.
   assign vec_addr = (DATA_W'(VEC_BASE) + DATA_W'(cause_idx)) & ~DATA_W'(3);
   assign lane     = 2'(cause_idx);

   always_comb begin : lane_select
      vec_byte = '0;
      case (lane)
         2'd0: vec_byte = bus.mem_data[31:24];
         2'd1: vec_byte = bus.mem_data[23:16];
         2'd2: vec_byte = bus.mem_data[15:8];
         2'd3: vec_byte = bus.mem_data[7:0];
         default: vec_byte = '0;
      endcase
   end

   always_comb begin : outputs
      bus.pc_load   = 1'b0;
      bus.pc_target = '0;
      if (state == VLOAD) begin
         bus.pc_load   = 1'b1;
         bus.pc_target = DATA_W'(vec_byte);
      end else if (eret_ok) begin
         bus.pc_load   = 1'b1;
         bus.pc_target = epc;
      end
   end

   assign bus.exc_active = (state != IDLE);
   assign bus.in_handler = in_handler;
   assign bus.epc        = epc;
   assign bus.cause      = DATA_W'(cause_idx);
   assign bus.pending    = pending;
   assign bus.mem_rd     = (state == VREQ) || (state == VWAIT);
   assign bus.mem_addr   = (state != IDLE) ? vec_addr : '0;
endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: a small-config instance (4 causes, latency 1)
// and a wide-config instance (8 causes, latency 3) share one stimulus/model path.
module tb_exception_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exception_unit_if #(.DATA_W(32), .N_CAUSES(4)) ia ();
   exception_unit_if #(.DATA_W(32), .N_CAUSES(8)) ib ();

   exception_unit #(.DATA_W(32), .N_CAUSES(4), .VEC_BASE(252), .MEM_LAT(1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   exception_unit #(.DATA_W(32), .N_CAUSES(8), .VEC_BASE(252), .MEM_LAT(3))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   // Stimulus goes to the selected instance; the idle one is fully masked.
   logic        sel = 1'b0;
   logic [7:0]  s_req = '0, s_mask = '0;
   logic        s_eret = 1'b0;
   logic [31:0] s_pc = '0;

   assign ia.exc_req  = sel ? 4'h0 : s_req[3:0];
   assign ia.exc_mask = sel ? 4'hF : s_mask[3:0];
   assign ia.eret     = !sel && s_eret;
   assign ia.pc_in    = s_pc;
   assign ib.exc_req  = sel ? s_req : 8'h00;
   assign ib.exc_mask = sel ? s_mask : 8'hFF;
   assign ib.eret     = sel && s_eret;
   assign ib.pc_in    = s_pc;

   // Vector memory: data only valid once the read has been outstanding long enough.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd252: return 32'h1122_3344;
         32'd256: return 32'hAABB_CCDD;
         default: return {a[15:0], ~a[15:0]};
      endcase
   endfunction

   int unsigned cnt_a = 0, cnt_b = 0;
   always @(posedge clk) cnt_a <= ia.mem_rd ? cnt_a + 1 : 0;
   always @(posedge clk) cnt_b <= ib.mem_rd ? cnt_b + 1 : 0;
   assign ia.mem_data = (cnt_a == 2) ? mem_word(ia.mem_addr) : 32'hDEAD_BEEF;
   assign ib.mem_data = (cnt_b == 4) ? mem_word(ib.mem_addr) : 32'hDEAD_BEEF;

   logic        o_active, o_in_handler, o_mem_rd, o_pc_load;
   logic [31:0] o_epc, o_cause, o_mem_addr, o_pc_target;
   logic [7:0]  o_pending;
   assign o_active     = sel ? ib.exc_active : ia.exc_active;
   assign o_in_handler = sel ? ib.in_handler : ia.in_handler;
   assign o_mem_rd     = sel ? ib.mem_rd     : ia.mem_rd;
   assign o_pc_load    = sel ? ib.pc_load    : ia.pc_load;
   assign o_epc        = sel ? ib.epc        : ia.epc;
   assign o_cause      = sel ? ib.cause      : ia.cause;
   assign o_mem_addr   = sel ? ib.mem_addr   : ia.mem_addr;
   assign o_pc_target  = sel ? ib.pc_target  : ia.pc_target;
   assign o_pending    = sel ? ib.pending    : {4'h0, ia.pending};

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: what the unit should hold, at transaction level.
   typedef struct packed {
      logic        is_eret;
      logic [31:0] target;
      logic [31:0] epc;
      logic [31:0] cause;
   } exp_t;
   exp_t        exp_q[$];
   int          cur_n = 4, cur_lat = 1;
   logic [7:0]  m_pend = '0;
   logic        m_in = 1'b0;
   logic [31:0] m_epc = '0;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_byte(input int idx);
      logic [31:0] w;
      w = mem_word(32'(252 + idx) & 32'hFFFF_FFFC);
      return (w >> (8 * (3 - (idx % 4)))) & 32'hFF;
   endfunction

   // Monitor: every pc_load must match the oldest expected event; otherwise target is 0.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_pc_load) begin
            if (exp_q.size() == 0) check("unexpected pc_load", 32'(o_pc_load), 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               check("pc_target", o_pc_target, mon_e.target);
               if (!mon_e.is_eret) begin
                  check("cause at load", o_cause, mon_e.cause);
                  check("epc at load", o_epc, mon_e.epc);
               end
            end
         end else begin
            check("pc_target idle", o_pc_target, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_req(input logic [7:0] req, input logic [31:0] pc);
      s_req  = req;
      s_pc   = pc;
      m_pend = m_pend | req;
      tick();
      s_req = '0;
   endtask

   task automatic set_mask(input logic [7:0] m);
      tick();
      s_mask = m;
   endtask

   task automatic run_exc(input int w);
      int          guard, cyc;
      logic [31:0] addr;
      exp_q.push_back('{is_eret: 1'b0, target: exp_byte(w), epc: s_pc, cause: 32'(w)});
      m_pend[w] = 1'b0;
      m_in      = 1'b1;
      m_epc     = s_pc;
      addr      = 32'(252 + w) & 32'hFFFF_FFFC;
      guard     = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!o_active && guard < 10);
      check("take latency", 32'(guard), 32'd2);
      cyc = 0;
      while (o_active && cyc < 20) begin
         check("mem_addr", o_mem_addr, addr);
         if (cyc < 1 + cur_lat) check("mem_rd", 32'(o_mem_rd), 32'd1);
         check("pc_load timing", 32'(o_pc_load), 32'(cyc == 1 + cur_lat));
         cyc++;
         @(negedge clk);
      end
      check("exc_active cycles", 32'(cyc), 32'(2 + cur_lat));
      check("in_handler set", 32'(o_in_handler), 32'd1);
      check("epc", o_epc, m_epc);
      check("cause", o_cause, 32'(w));
      check("pending after take", 32'(o_pending), 32'(m_pend));
   endtask

   task automatic settle();
      int w;
      w = lowest(m_pend & ~s_mask);
      if (!m_in && w >= 0) run_exc(w);
   endtask

   task automatic do_eret();
      logic exp_load;
      tick();
      exp_load = m_in;
      s_eret   = 1'b1;
      if (m_in) begin
         exp_q.push_back('{is_eret: 1'b1, target: m_epc, epc: 32'd0, cause: 32'd0});
         m_in = 1'b0;
      end
      @(negedge clk);
      check("eret pc_load", 32'(o_pc_load), 32'(exp_load));
      tick();
      s_eret = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " exc_active"}, 32'(o_active), 32'd0);
      check({tag, " in_handler"}, 32'(o_in_handler), 32'd0);
      check({tag, " pending"}, 32'(o_pending), 32'd0);
      check({tag, " epc"}, o_epc, 32'd0);
      check({tag, " cause"}, o_cause, 32'd0);
      check({tag, " pc_load"}, 32'(o_pc_load), 32'd0);
      check({tag, " mem_rd"}, 32'(o_mem_rd), 32'd0);
   endtask

   initial begin
      int guard;
      logic [7:0] all;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      check("reset mem_addr", o_mem_addr, 32'd0);
      rst_n = 1'b1;

      // Single cause, then two simultaneous causes with ERET/pending collision.
      issue_req(8'b0010, 32'h40);
      settle();
      do_eret();
      issue_req(8'b0101, 32'h80);
      settle();
      do_eret();
      settle();
      do_eret();

      // Masked cause stays pending until unmasked.
      set_mask(8'b0010);
      issue_req(8'b0010, 32'hC0);
      repeat (3) @(negedge clk);
      check("masked not taken", 32'(o_active), 32'd0);
      check("masked pending", 32'(o_pending), 32'b0010);
      set_mask(8'h00);
      settle();
      do_eret();

      // Request during handler is held; stray ERET is ignored.
      issue_req(8'b0001, 32'h100);
      settle();
      issue_req(8'b1000, 32'h104);
      repeat (2) @(negedge clk);
      check("held pending", 32'(o_pending), 32'b1000);
      check("held no nest", 32'(o_active), 32'd0);
      do_eret();
      settle();
      do_eret();
      do_eret();

      // Randomised traffic against the model.
      all = 8'h0F;
      repeat (30) begin
         issue_req(8'($urandom) & all, $urandom & 32'hFFFF_FFFC);
         settle();
         if (m_in && $urandom_range(0, 1) == 1) s_mask = 8'($urandom) & all;
         if ($urandom_range(0, 1) == 1) issue_req(8'($urandom) & all, $urandom & 32'hFFFF_FFFC);
         settle();
         do_eret();
         settle();
      end
      if (m_in) do_eret();
      set_mask(8'h00);
      settle();
      for (int k = 0; k < 10 && m_in; k++) begin
         do_eret();
         settle();
      end
      check("drained pending", 32'(o_pending), 32'(m_pend));

      // Wide instance: 8 causes, three-cycle vector latency.
      tick();
      sel = 1'b1; cur_n = 8; cur_lat = 3; s_mask = 8'h00;
      m_pend = '0; m_in = 1'b0;
      issue_req(8'b0010_0000, 32'h200);
      settle();
      do_eret();

      // Reset in the middle of VWAIT.
      issue_req(8'b0010_0100, 32'h300);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!o_active && guard < 10);
      check("reset test started", 32'(o_active), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_cleared("mid reset");
      check("mid reset pc_target", o_pc_target, 32'd0);
      m_pend = '0; m_in = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_cleared("post reset");

      issue_req(8'b1000_0000, 32'h400);
      settle();
      do_eret();
      repeat (2) @(negedge clk);
      check("scoreboard empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
